// File: rtl/clk_enable_nco.sv
// clk_enable_nco: multi-channel fractional clock-enable NCO with glitch-free run-time retune
module clk_enable_nco #(
  parameter int NUM_CH = 4,
  parameter int ACC_W = 24,
  parameter logic [NUM_CH*ACC_W-1:0] DEF_INC = '0,
  parameter logic [NUM_CH-1:0] DEF_EN = '1,
  parameter int LOCK_CYC = 1024,
  localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1,
  localparam int CNT_W = $clog2(LOCK_CYC + 1)
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [ACC_W-1:0]  cfg_inc,
  input  logic              cfg_en,
  output logic [NUM_CH-1:0] ce,
  output logic [NUM_CH-1:0] clk_sq,
  output logic              locked
);
  logic [ACC_W-1:0] acc [NUM_CH];
  logic [ACC_W-1:0] inc [NUM_CH];
  logic [NUM_CH-1:0] en, carry;
  logic pend, done, apply, tgt_en, tgt_zero, tgt_carry, p_en;
  logic [CH_W-1:0] p_ch;
  logic [ACC_W-1:0] p_inc;
  logic [CNT_W-1:0] cnt;
  assign cfg_ready = ~pend & ~done;
  // Disables, idle targets and unknown channels apply at once; live channels wait for their carry.
  always_comb begin
    tgt_en = 1'b0;
    tgt_zero = 1'b1;
    tgt_carry = 1'b0;
    for (int i = 0; i < NUM_CH; i++)
      if (int'(p_ch) == i) begin
        tgt_en = en[i];
        tgt_zero = inc[i] == '0;
        tgt_carry = carry[i];
      end
    apply = pend & (~tgt_en | tgt_zero | ~p_en | tgt_carry);
  end
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [ACC_W:0] sum;
    logic hit, keep;
    assign sum = {1'b0, acc[g]} + {1'b0, inc[g]};
    assign carry[g] = en[g] & sum[ACC_W];
    assign hit = apply && int'(p_ch) == g;
    assign keep = en[g] & ~(hit & ~p_en);
    always_ff @(posedge refclk) begin
      if (rst) begin
        acc[g] <= '0;
        inc[g] <= DEF_INC[g*ACC_W +: ACC_W];
        en[g] <= DEF_EN[g];
        ce[g] <= 1'b0;
        clk_sq[g] <= 1'b0;
      end else begin
        acc[g] <= keep ? sum[ACC_W-1:0] : '0;
        ce[g] <= keep & sum[ACC_W];
        clk_sq[g] <= keep & (clk_sq[g] ^ sum[ACC_W]);
        if (hit) begin
          inc[g] <= p_inc;
          en[g] <= p_en;
        end
      end
    end
  end
  always_ff @(posedge refclk) begin
    if (rst) begin
      pend <= 1'b0;
      done <= 1'b0;
      cnt <= '0;
      locked <= 1'b0;
      p_ch <= '0;
      p_inc <= '0;
      p_en <= 1'b0;
    end else begin
      done <= apply;
      if (cfg_valid & cfg_ready) begin
        pend <= 1'b1;
        p_ch <= cfg_ch;
        p_inc <= cfg_inc;
        p_en <= cfg_en;
      end else if (apply) pend <= 1'b0;
      cnt <= apply ? '0 : (cnt == CNT_W'(LOCK_CYC) ? cnt : cnt + 1'b1);
      locked <= ~apply & (cnt == CNT_W'(LOCK_CYC));
    end
  end
endmodule

// File: tb/tb_clk_enable_nco.sv
// tb_clk_enable_nco: directed checks of pulse rates, retune, disable, reset and lock timing
module tb_clk_enable_nco;
  logic refclk = 1'b0;
  logic rst, cfg_valid, cfg_ready, cfg_en, locked;
  logic [1:0] cfg_ch;
  logic [3:0] cfg_inc, ce, clk_sq;
  int checks = 0;
  int errors = 0;
  always #5 refclk = ~refclk;
  clk_enable_nco #(
    .NUM_CH(4), .ACC_W(4), .DEF_INC(16'h3444), .DEF_EN(4'hF), .LOCK_CYC(8)
  ) dut (
    .refclk(refclk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_inc(cfg_inc), .cfg_en(cfg_en),
    .ce(ce), .clk_sq(clk_sq), .locked(locked)
  );
  task automatic tick;
    @(posedge refclk);
    #1;
  endtask
  task automatic test_reset;
    rst = 1'b1; cfg_valid = 1'b0; cfg_ch = '0; cfg_inc = '0; cfg_en = 1'b0;
    tick(); tick();
    checks++; if (ce !== 4'h0) begin errors++; $display("FAIL reset_ce got %h want 0", ce); end
    checks++; if (clk_sq !== 4'h0) begin errors++; $display("FAIL reset_sq got %h want 0", clk_sq); end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", cfg_ready); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked got %b want 0", locked); end
    rst = 1'b0;
  endtask
  task automatic test_rate;
    for (int k = 1; k <= 32; k++) begin
      tick();
      checks++; if (ce[0] !== (k % 4 == 0)) begin errors++; $display("FAIL rate_ce0 k=%0d got %b", k, ce[0]); end
      checks++; if (ce[1] !== (k % 4 == 0)) begin errors++; $display("FAIL rate_ce1 k=%0d got %b", k, ce[1]); end
      checks++; if (clk_sq[0] !== ((k / 4) % 2 == 1)) begin errors++; $display("FAIL rate_sq0 k=%0d got %b", k, clk_sq[0]); end
      checks++; if (ce[3] !== (k % 16 == 6 || k % 16 == 11 || k % 16 == 0)) begin errors++; $display("FAIL rate_ce3 k=%0d got %b", k, ce[3]); end
      checks++; if (locked !== (k >= 9)) begin errors++; $display("FAIL lock_rise k=%0d got %b want %b", k, locked, k >= 9); end
    end
  endtask
  task automatic test_retune;
    cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_inc = 4'd8; cfg_en = 1'b1;
    for (int j = 1; j <= 14; j++) begin
      tick();
      if (j == 1) cfg_valid = 1'b0;
      checks++; if (ce[1] !== (j >= 4 && j % 2 == 0)) begin errors++; $display("FAIL retune_ce1 j=%0d got %b", j, ce[1]); end
      checks++; if (ce[0] !== (j % 4 == 0)) begin errors++; $display("FAIL retune_ce0 j=%0d got %b", j, ce[0]); end
      checks++; if (cfg_ready !== (j >= 5)) begin errors++; $display("FAIL retune_ready j=%0d got %b want %b", j, cfg_ready, j >= 5); end
      checks++; if (locked !== (j < 4 || j >= 13)) begin errors++; $display("FAIL retune_locked j=%0d got %b", j, locked); end
    end
  endtask
  task automatic test_disable;
    cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_inc = 4'd4; cfg_en = 1'b0;
    for (int j = 1; j <= 14; j++) begin
      tick();
      if (j == 1 || j == 4) cfg_valid = 1'b0;
      if (j == 3) begin cfg_valid = 1'b1; cfg_en = 1'b1; end
      checks++; if (ce[2] !== (j == 9 || j == 13)) begin errors++; $display("FAIL dis_ce2 j=%0d got %b", j, ce[2]); end
      if (j >= 2) begin
        checks++; if (clk_sq[2] !== (j >= 9 && j < 13)) begin errors++; $display("FAIL dis_sq2 j=%0d got %b", j, clk_sq[2]); end
      end
      checks++; if (cfg_ready !== !(j == 1 || j == 2 || j == 4 || j == 5)) begin errors++; $display("FAIL dis_ready j=%0d got %b", j, cfg_ready); end
    end
  endtask
  task automatic test_reset_pending;
    cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_inc = 4'd3; cfg_en = 1'b0;
    tick();
    cfg_valid = 1'b0;
    tick(); tick();
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL rp_ready_pre got %b want 1", cfg_ready); end
    cfg_valid = 1'b1; cfg_inc = 4'd5; cfg_en = 1'b1;
    tick();
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL rp_accept got %b want 0", cfg_ready); end
    checks++; if (ce[3] !== 1'b0) begin errors++; $display("FAIL rp_ce3_off got %b want 0", ce[3]); end
    cfg_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (ce !== 4'h0) begin errors++; $display("FAIL rp_ce got %h want 0", ce); end
    checks++; if (clk_sq !== 4'h0) begin errors++; $display("FAIL rp_sq got %h want 0", clk_sq); end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL rp_ready got %b want 1", cfg_ready); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL rp_locked got %b want 0", locked); end
    for (int k = 1; k <= 12; k++) begin
      tick();
      checks++; if (ce[3] !== (k == 6 || k == 11)) begin errors++; $display("FAIL rp_ce3 k=%0d got %b", k, ce[3]); end
      checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL rp_ready_post k=%0d got %b", k, cfg_ready); end
      checks++; if (ce[0] !== (k % 4 == 0)) begin errors++; $display("FAIL rp_ce0 k=%0d got %b", k, ce[0]); end
    end
  endtask
  initial begin
    test_reset();
    test_rate();
    test_retune();
    test_disable();
    test_reset_pending();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
